// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the instruction/data RAM arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} arb_state_t;

    localparam int ARB_STARVE_MAX = 4;
    localparam int ARB_TIMEOUT    = 15;

    // A RAM that reports FREE while we hold a strobe has not answered yet, so it counts as busy.
    function automatic logic is_busy(input ramstate_t s);
        return s == BUSY || s == FREE;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating busy-cycle counter that pulses timeout on its last allowed cycle
module arb_watchdog #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    // Count busy cycles, holding at the last value until the owner clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != LAST) cnt <= cnt + 1'b1;
    end

    assign timeout = en && cnt == LAST;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory, data first
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    parameter int TIMEOUT    = ARB_TIMEOUT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    arb_state_t        state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic [SW-1:0]     starve_cnt;
    logic              d_req, in_acc, live, busy, done, timeout, fault, grant_d, wd_clr;

    assign d_req   = dREN | dWEN;
    assign in_acc  = state != IDLE;
    assign live    = (state == I_ACC) ? iREN : (state == D_ACC) ? d_req : 1'b0;
    assign busy    = live && is_busy(ramstate);
    assign done    = live && ramstate == ACCESS;
    assign grant_d = d_req && starve_cnt < SMAX;

    arb_watchdog #(.MAX(TIMEOUT)) u_wd (
        .clk     (CLK),
        .rst_n   (nRST),
        .clr     (wd_clr),
        .en      (busy),
        .timeout (timeout)
    );

    // Next state and all port/RAM outputs; strobes follow the live request so a drop releases the RAM at once.
    always_comb begin
        fault      = live && (ramstate == ERROR || timeout);
        state_next = !in_acc ? (grant_d ? D_ACC : iREN ? I_ACC : IDLE)
                   : (!live || done || fault) ? IDLE : state;
        wd_clr     = state_next != state;
        ramREN     = live && !wr_q;
        ramWEN     = live && wr_q;
        ramaddr    = in_acc ? addr_q : '0;
        ramstore   = in_acc ? data_q : '0;
        iwait      = !(state == I_ACC && (done || fault));
        dwait      = !(state == D_ACC && (done || fault));
        iload      = (state == I_ACC && done) ? ramload : '0;
        dload      = (state == D_ACC && done && !wr_q) ? ramload : '0;
        err        = fault;
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else state <= state_next;
    end

    // Capture the winning port's address, write data and op type at grant time.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (!in_acc && state_next != IDLE) begin
            addr_q <= grant_d ? daddr : iaddr;
            data_q <= grant_d ? dstore : '0;
            wr_q   <= grant_d && dWEN;
        end
    end

    // Count data completions that overtook a waiting fetch; reaching the limit hands the next slot to fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) starve_cnt <= '0;
        else if (!iREN || (state == I_ACC && done)) starve_cnt <= '0;
        else if (state == D_ACC && done && starve_cnt < SMAX) starve_cnt <= starve_cnt + 1'b1;
    end

endmodule
